// File: rtl/ez8_pkg.sv
// Shared ez8 core definitions: PC width, flow-control states, vector spacing.
package ez8_pkg;
  localparam int PC_W          = 12;
  localparam int VECTOR_STRIDE = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ISR  = 2'd1,
    HALT = 2'd2
  } flow_state_t;
endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO with a combinational top-of-stack read.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = AW'(cnt_q - ONE);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = mem_q[rd_idx];

  // Erroring operations (push on full, pop on empty) leave the pointer alone.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)       cnt_d = cnt_q + ONE;
    else if (pop && !empty)  cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
    if (!reset && push && !full) mem_q[wr_idx] <= din;
  end
endmodule

// File: rtl/flow_ctrl.sv
// Control-flow sequencer: arbitrates ret/call/branch/irq into PC goto/pause.
// Interrupt logic and the ISR state exist only when FLOW_CTRL_IRQ_EN is defined.
module flow_ctrl
  import ez8_pkg::*;
#(
  parameter int              STACK_DEPTH = 8,
  parameter int              NUM_IRQ     = 4,
  parameter logic [PC_W-1:0] VECTOR_BASE = 12'h004
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               kill,
  input  logic               stall_req,
  input  logic               branch_req,
  input  logic [PC_W-1:0]    branch_addr,
  input  logic               call_req,
  input  logic [PC_W-1:0]    call_addr,
  input  logic               ret_req,
  input  logic               reti_req,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_en,
  output logic               goto,
  output logic [PC_W-1:0]    goto_addr,
  output logic               pause,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic               stack_err
);
  flow_state_t        state_q, state_d;
  logic               err_q, err_d;
  logic               st_push, st_pop, st_full, st_empty;
  logic [PC_W-1:0]    st_top, st_din;
  logic [NUM_IRQ-1:0] pend_clr, ack_c, vec_oh;
  logic [PC_W-1:0]    vec_addr;
  logic               irq_pend;

  assign st_din = pc_in - PC_W'(1);

  ret_stack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (st_push),
    .pop   (st_pop),
    .din   (st_din),
    .top   (st_top),
    .full  (st_full),
    .empty (st_empty)
  );

`ifdef FLOW_CTRL_IRQ_EN
  logic [NUM_IRQ-1:0] irq_s_q, irq_p_q, pend_q, pend_d;

  // Edge history is seeded from the live lines in reset so lines held high
  // across reset release never look like a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_s_q <= irq;
      irq_p_q <= irq;
      pend_q  <= '0;
    end else begin
      irq_s_q <= irq;
      irq_p_q <= irq_s_q;
      pend_q  <= pend_d;
    end
  end

  assign pend_d = (pend_q & ~pend_clr) | (irq_s_q & ~irq_p_q);

  always_comb begin
    vec_oh   = '0;
    vec_addr = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (pend_q[i]) begin
        vec_oh    = '0;
        vec_oh[i] = 1'b1;
        vec_addr  = VECTOR_BASE + PC_W'(VECTOR_STRIDE * i);
      end
    end
  end

  assign irq_pend = (state_q == RUN) && irq_en && (|pend_q);
  assign irq_ack  = ack_c;
  assign in_isr   = (state_q == ISR);
`else
  logic unused_irq;
  assign unused_irq = &{1'b0, irq, irq_en, pend_clr, ack_c};
  assign vec_oh     = '0;
  assign vec_addr   = '0;
  assign irq_pend   = 1'b0;
  assign irq_ack    = '0;
  assign in_isr     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    st_push   = 1'b0;
    st_pop    = 1'b0;
    goto      = 1'b0;
    goto_addr = '0;
    ack_c     = '0;
    pend_clr  = '0;
    pause     = stall_req | (state_q == HALT);
    if (!reset && !pause && !kill) begin
      if (ret_req || reti_req) begin
        if (st_empty) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          st_pop    = 1'b1;
          goto      = 1'b1;
          goto_addr = st_top;
          if (reti_req && state_q == ISR) state_d = RUN;
        end
      end else if (call_req) begin
        if (st_full) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          st_push   = 1'b1;
          goto      = 1'b1;
          goto_addr = call_addr;
        end
      end else if (branch_req) begin
        goto      = 1'b1;
        goto_addr = branch_addr;
      end else if (irq_pend) begin
        if (st_full) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          st_push   = 1'b1;
          goto      = 1'b1;
          goto_addr = vec_addr;
          ack_c     = vec_oh;
          pend_clr  = vec_oh;
          state_d   = ISR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign stack_err = err_q;
endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl: vector table plus hand-written stack/irq sequences.
`timescale 1ns/1ps
module tb_flow_ctrl;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   pc_in, branch_addr, call_addr, goto_addr;
  logic          kill, stall_req, branch_req, call_req, ret_req, reti_req, irq_en;
  logic [NI-1:0] irq, irq_ack;
  logic          goto, pause, in_isr, stack_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flow_ctrl #(.STACK_DEPTH(8), .NUM_IRQ(NI), .VECTOR_BASE(12'h004)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .kill(kill), .stall_req(stall_req),
    .branch_req(branch_req), .branch_addr(branch_addr), .call_req(call_req),
    .call_addr(call_addr), .ret_req(ret_req), .reti_req(reti_req), .irq(irq),
    .irq_en(irq_en), .goto(goto), .goto_addr(goto_addr), .pause(pause),
    .irq_ack(irq_ack), .in_isr(in_isr), .stack_err(stack_err)
  );

  typedef struct packed {
    logic        stall, kl, br, call, ret, reti;
    logic [11:0] pc, br_a, call_a;
    logic        e_goto;
    logic [11:0] e_addr;
    logic        e_pause;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    kill = 0; stall_req = 0; branch_req = 0; call_req = 0; ret_req = 0; reti_req = 0;
    pc_in = '0; branch_addr = '0; call_addr = '0;
  endtask

  task automatic do_reset();
    clr_req();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic go_chk(input string nm, input logic eg, input logic [11:0] ea);
    #1;
    chk({nm, " goto"}, {11'd0, goto}, {11'd0, eg});
    chk({nm, " addr"}, goto_addr, ea);
  endtask

  initial begin
    irq = '0; irq_en = 0;
    clr_req();
    reset = 1;
    tick();
    tick();
    // requests during reset produce nothing
    branch_req = 1; branch_addr = 12'hABC; stall_req = 1;
    go_chk("rst", 0, 12'h000);
    chk("rst pause stall", {11'd0, pause}, 12'd1);
    chk("rst err", {11'd0, stack_err}, 12'd0);
    chk("rst ack", {8'd0, irq_ack}, 12'd0);
    chk("rst in_isr", {11'd0, in_isr}, 12'd0);
    stall_req = 0;
    #1 chk("rst pause", {11'd0, pause}, 12'd0);
    clr_req();
    tick();
    reset = 0;

    //                stall kl br call ret reti  pc      br_a    call_a  goto addr  pause
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000,12'h000, 1'b0,12'h000,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 12'h010,12'h000,12'h100, 1'b1,12'h100,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 12'h000,12'h055,12'h000, 1'b0,12'h000,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 12'h000,12'h000,12'h000, 1'b0,12'h000,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 12'h030,12'h000,12'h200, 1'b0,12'h000,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 12'h000,12'h123,12'h000, 1'b1,12'h123,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 12'h050,12'h000,12'h300, 1'b1,12'h300,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 12'h000,12'h000,12'h000, 1'b1,12'h04F,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 12'h000,12'h000,12'h000, 1'b1,12'h00F,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 12'h061,12'h777,12'h400, 1'b1,12'h400,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 12'h000,12'h777,12'h000, 1'b1,12'h060,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 12'h000,12'h000,12'h000, 1'b0,12'h000,1'b1};

    foreach (tbl[i]) begin
      stall_req = tbl[i].stall; kill = tbl[i].kl; branch_req = tbl[i].br;
      call_req = tbl[i].call; ret_req = tbl[i].ret; reti_req = tbl[i].reti;
      pc_in = tbl[i].pc; branch_addr = tbl[i].br_a; call_addr = tbl[i].call_a;
      go_chk($sformatf("vec%0d", i), tbl[i].e_goto, tbl[i].e_addr);
      chk($sformatf("vec%0d pause", i), {11'd0, pause}, {11'd0, tbl[i].e_pause});
      tick();
    end
    clr_req();
    chk("tbl err", {11'd0, stack_err}, 12'd0);

    // underflow: stack is empty here
    ret_req = 1;
    go_chk("under", 0, 12'h000);
    tick();
    clr_req();
    #1 chk("under err", {11'd0, stack_err}, 12'd1);
    chk("under pause", {11'd0, pause}, 12'd1);
    branch_req = 1; branch_addr = 12'h321;
    go_chk("halt br", 0, 12'h000);
    tick();
    do_reset();
    #1 chk("under rst err", {11'd0, stack_err}, 12'd0);
    chk("under rst pause", {11'd0, pause}, 12'd0);

    // overflow: fill 8 deep, pop one, refill, then the 9th push errors
    for (int i = 0; i < 8; i++) begin
      call_req = 1; pc_in = 12'h101 + 12'(i); call_addr = 12'h200 + 12'(i);
      go_chk($sformatf("ovf call%0d", i), 1, 12'h200 + 12'(i));
      tick();
    end
    clr_req(); ret_req = 1;
    go_chk("ovf ret", 1, 12'h107);
    tick();
    clr_req(); call_req = 1; pc_in = 12'h201; call_addr = 12'h3AA;
    go_chk("ovf refill", 1, 12'h3AA);
    tick();
    pc_in = 12'h301; call_addr = 12'h3BB;
    go_chk("ovf 9th", 0, 12'h000);
    tick();
    clr_req();
    #1 chk("ovf err", {11'd0, stack_err}, 12'd1);
    chk("ovf pause", {11'd0, pause}, 12'd1);
    ret_req = 1;
    go_chk("ovf halt ret", 0, 12'h000);
    tick();
    #1 chk("ovf pause held", {11'd0, pause}, 12'd1);
    do_reset();
    #1 chk("ovf rst err", {11'd0, stack_err}, 12'd0);

`ifdef FLOW_CTRL_IRQ_EN
    // bit 0 already high at reset release must not pend
    irq = 4'b0001;
    do_reset();
    irq_en = 1;
    go_chk("irq held0", 0, 12'h000);
    tick();
    go_chk("irq held1", 0, 12'h000);
    tick();
    irq = 4'b1011; pc_in = 12'h020;
    go_chk("irq c0", 0, 12'h000);
    tick();
    go_chk("irq c1", 0, 12'h000);
    tick();
    go_chk("irq entry", 1, 12'h008);
    chk("irq ack1", {8'd0, irq_ack}, 12'h002);
    tick();
    #1 chk("irq in_isr", {11'd0, in_isr}, 12'd1);
    chk("irq ack pulse", {8'd0, irq_ack}, 12'h000);
    kill = 1;
    go_chk("isr kill0", 0, 12'h000);
    tick();
    go_chk("isr kill1", 0, 12'h000);
    tick();
    kill = 0;
    go_chk("isr no nest", 0, 12'h000);
    chk("isr no ack", {8'd0, irq_ack}, 12'h000);
    tick();
    reti_req = 1;
    go_chk("reti1", 1, 12'h01F);
    tick();
    reti_req = 0;
    #1 chk("reti1 in_isr", {11'd0, in_isr}, 12'd0);
    kill = 1;
    go_chk("reti kill0", 0, 12'h000);
    tick();
    go_chk("reti kill1", 0, 12'h000);
    tick();
    kill = 0;
    go_chk("irq3 entry", 1, 12'h010);
    chk("irq ack3", {8'd0, irq_ack}, 12'h008);
    tick();
    reti_req = 1;
    go_chk("reti3", 1, 12'h01F);
    tick();
    reti_req = 0;
    #1 chk("reti3 in_isr", {11'd0, in_isr}, 12'd0);

    // branch beats a pending irq; irq lands after the two kill cycles
    irq_en = 0; irq = 4'b0000;
    tick();
    irq = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      go_chk($sformatf("irq masked%0d", i), 0, 12'h000);
      tick();
    end
    irq_en = 1; branch_req = 1; branch_addr = 12'h456;
    go_chk("sim branch", 1, 12'h456);
    chk("sim no ack", {8'd0, irq_ack}, 12'h000);
    tick();
    branch_req = 0; kill = 1;
    go_chk("sim kill0", 0, 12'h000);
    tick();
    go_chk("sim kill1", 0, 12'h000);
    tick();
    kill = 0;
    go_chk("sim irq2", 1, 12'h00C);
    chk("sim ack2", {8'd0, irq_ack}, 12'h004);
    tick();
`else
    irq_en = 1; irq = 4'b0000;
    tick();
    irq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      go_chk($sformatf("noirq%0d", i), 0, 12'h000);
      chk($sformatf("noirq%0d ack", i), {8'd0, irq_ack}, 12'h000);
      chk($sformatf("noirq%0d isr", i), {11'd0, in_isr}, 12'd0);
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
